neigh_fifo_mc: RTL and testbench
================================

// Module: neigh_fifo_mc
// PURPOSE
//  Multi-channel neighbour-PE FIFO bank, replacing the single-channel neighbour FIFO.
//  NUM_CH independent FIFOs buffer writes from neighbour PEs.
//  Each channel serves reads from its own stall-aware request line and holds its output while the pipeline is stalled.
//  Adds occupancy counts, almost-full flags, and full-drop protection.
//  Sits between bus-arbiter neighbour ports and the PE operand-fetch stage.
// PARAMETERS
//  LEN       16  data word width (bits)
//  DEPTH     4   entries per channel; power of two, >=2
//  PTR       2   pointer width; must equal $clog2(DEPTH)
//  NUM_CH    2   number of independent channels, >=1
//  AF_MARGIN 1   almost_full asserts when count >= DEPTH-AF_MARGIN; range 0..DEPTH-1
// PORTS
//  clk            in   1            clock, all logic rising-edge
//  rst            in   1            asynchronous active-high reset
//  stall          in   1            global pipeline stall, shared by all channels
//  data_in        in   NUM_CH*LEN   write data, channel c at [c*LEN +: LEN]
//  data_in_valid  in   NUM_CH       per-channel write strobe
//  rd_rqst        in   NUM_CH       per-channel read request (sampled only when ~stall)
//  full           out  NUM_CH       channel count == DEPTH (combinational from state)
//  almost_full    out  NUM_CH       channel count >= DEPTH-AF_MARGIN
//  count          out  NUM_CH*(PTR+1) per-channel occupancy 0..DEPTH
//  data_out       out  NUM_CH*LEN   registered read data
//  data_out_valid out  NUM_CH       registered read-data valid
//  ovf_cnt        out  NUM_CH*8     dropped-write counters (present only under NEIGH_FIFO_OVF_CNT_EN)
// BEHAVIOUR  (per channel c, all channels identical and independent)
//  Reset: pointers, count, rq, data_out_valid = 0; data_out = 0; full = 0; almost_full = (AF_MARGIN==DEPTH).
//  Request latch rq:
//   - ~stall: rq <= rd_rqst[c].
//   - stall:  rq <= rd_en ? 0 : rq. A pending request is served at most once during a stall.
//  rd_en = rq & (count != 0).
//  wr_en = data_in_valid[c] & (~full | rd_en).
//  Read latency: 1 cycle. data_out <= mem[rd_ptr] on rd_en; otherwise data_out holds its value.
//  data_out_valid <= (data_out_valid & stall) | rd_en. Valid and data stay constant while stall is held.
//  count: +1 on wr_en only; -1 on rd_en only; unchanged when both or neither fire.
//  Pointers wrap modulo DEPTH (natural PTR-bit overflow).
//  Boundary conditions:
//   - Write while full with no read: write dropped; state unchanged.
//   - Write while full with a same-cycle read: write accepted; count stays DEPTH.
//   - Request on empty: no read; rq stays set, and a read issues in the first cycle count != 0.
//     If ~stall and rd_rqst has dropped, rq clears instead.
//   - Write into empty with rq set: data is readable the next cycle, not the same cycle (no bypass).
//   - rst asserted mid-operation: all state clears immediately; in-flight data is lost.
// CONFIGURATION
//  `define NEIGH_FIFO_OVF_CNT_EN:
//   - Present: per-channel 8-bit counter increments on each dropped write (data_in_valid & full & ~rd_en).
//     Saturates at 255; cleared only by rst. ovf_cnt port exists.
//   - Absent: no counters and no ovf_cnt port. Dropped writes are silently discarded.
// STRUCTURE
//  Shared package neigh_fifo_pkg holds:
//   - channel-slice helper functions
//   - the OVF_W=8 constant
//   - the count-width rule PTR+1
//  Sub-module neigh_fifo_ch: one channel containing memory, pointers, count, rq latch, output register
//  and the optional counter. Top level is a generate loop over NUM_CH plus port slicing only.
// TESTING
//  1. LEN=16, DEPTH=4, NUM_CH=2. Write 0xA1,0xA2 to ch0; rd_rqst[0]=1 two cycles
//     -> data_out_valid[0] pulses on 2 consecutive cycles with 0xA1,0xA2; ch1 count stays 0.
//  2. Write 5 words to ch1 (DEPTH=4), no reads
//     -> full[1]=1 after 4th write; 5th dropped; count[1]=4; ovf_cnt[1]=1 when macro defined.
//  3. ch0 full; same cycle write 0xB5 and read
//     -> write accepted, count stays 4; 0xB5 read out 4 reads later in order.
//  4. Read issued, then stall=1 for 3 cycles with rd_rqst=1
//     -> data_out/valid held constant 3 cycles; no extra read; count drops by 1 only.
//  5. rd_rqst on empty ch0, then write 0xC3 while ~stall and rd_rqst held
//     -> valid asserts 2 cycles after write with 0xC3; AF_MARGIN=1 gives almost_full at count 3.
//  6. Assert rst mid-traffic with ch0 count=2
//     -> next cycle count=0, valid=0, full=0; subsequent write/read round-trips correctly.

Source files
------------

// File: rtl/neigh_fifo_pkg.sv
// Shared definitions for the multi-channel neighbour FIFO bank:
// counter width, occupancy-count width rule and channel slicing helpers.
package neigh_fifo_pkg;

  // Width of each per-channel dropped-write counter
  localparam int OVF_W = 8;

  // Occupancy needs one more bit than the pointer to represent DEPTH itself
  function automatic int cnt_w(input int ptr);
    return ptr + 1;
  endfunction

  // Low bit index of channel ch inside a flat bus of w-bit lanes
  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/neigh_fifo_ch.sv
// One neighbour FIFO channel: storage, pointers, occupancy, stall-aware
// request latch and registered read port.
// Optional dropped-write counter under NEIGH_FIFO_OVF_CNT_EN.
module neigh_fifo_ch
  import neigh_fifo_pkg::*;
#(
  parameter int LEN       = 16,
  parameter int DEPTH     = 4,
  parameter int PTR       = 2,
  parameter int AF_MARGIN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic [LEN-1:0]          wr_data,
  input  logic                    wr_valid,
  input  logic                    rd_rqst,
  output logic                    full,
  output logic                    almost_full,
  output logic [cnt_w(PTR)-1:0]   count,
  output logic [LEN-1:0]          rd_data,
  output logic                    rd_valid
`ifdef NEIGH_FIFO_OVF_CNT_EN
  ,
  output logic [OVF_W-1:0]        ovf_cnt
`endif
);

  localparam int CW = cnt_w(PTR);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH   = CW'(DEPTH - AF_MARGIN);

  logic [LEN-1:0] mem [DEPTH];
  logic [PTR-1:0] wr_ptr_p0;
  logic [PTR-1:0] rd_ptr_p0;
  logic [CW-1:0]  cnt_p0;
  logic           rq_p0;
  logic [LEN-1:0] dout_p1;
  logic           vld_p1;
  logic           rd_en;
  logic           wr_en;

  assign full        = (cnt_p0 == DEPTH_C);
  assign almost_full = (cnt_p0 >= AF_TH);
  assign count       = cnt_p0;
  assign rd_data     = dout_p1;
  assign rd_valid    = vld_p1;

  // A same-cycle read frees the slot the write lands in, so a full FIFO may still accept
  assign rd_en = rq_p0 & (cnt_p0 != '0);
  assign wr_en = wr_valid & (~full | rd_en);

  // Storage array: data only, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_p0] <= wr_data;
  end

  // Pointers, occupancy and request latch (stage p0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      cnt_p0    <= '0;
      rq_p0     <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
      if (rd_en) rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt_p0 <= cnt_p0 + 1'b1;
        2'b01:   cnt_p0 <= cnt_p0 - 1'b1;
        default: cnt_p0 <= cnt_p0;
      endcase
      // During a stall a pending request is consumed by its read and not re-armed
      if (!stall)     rq_p0 <= rd_rqst;
      else if (rd_en) rq_p0 <= 1'b0;
    end
  end

  // Registered read port (stage p1): data and valid freeze while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      if (rd_en) dout_p1 <= mem[rd_ptr_p0];
      vld_p1 <= (vld_p1 & stall) | rd_en;
    end
  end

`ifdef NEIGH_FIFO_OVF_CNT_EN
  logic [OVF_W-1:0] ovf_p0;
  logic             drop;

  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (v == {OVF_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign drop    = wr_valid & full & ~rd_en;
  assign ovf_cnt = ovf_p0;

  // Dropped-write counter, saturating, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ovf_p0 <= '0;
    else if (drop) ovf_p0 <= sat_inc(ovf_p0);
  end
`endif

endmodule

// File: rtl/neigh_fifo_mc.sv
// Multi-channel neighbour-PE FIFO bank: NUM_CH independent channels
// between the bus-arbiter neighbour ports and PE operand fetch.
// Define NEIGH_FIFO_OVF_CNT_EN to add per-channel dropped-write counters.
module neigh_fifo_mc
  import neigh_fifo_pkg::*;
#(
  parameter int LEN       = 16,
  parameter int DEPTH     = 4,
  parameter int PTR       = 2,
  parameter int NUM_CH    = 2,
  parameter int AF_MARGIN = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            stall,
  input  logic [NUM_CH*LEN-1:0]           data_in,
  input  logic [NUM_CH-1:0]               data_in_valid,
  input  logic [NUM_CH-1:0]               rd_rqst,
  output logic [NUM_CH-1:0]               full,
  output logic [NUM_CH-1:0]               almost_full,
  output logic [NUM_CH*cnt_w(PTR)-1:0]    count,
  output logic [NUM_CH*LEN-1:0]           data_out,
  output logic [NUM_CH-1:0]               data_out_valid
`ifdef NEIGH_FIFO_OVF_CNT_EN
  ,
  output logic [NUM_CH*OVF_W-1:0]         ovf_cnt
`endif
);

  localparam int CW = cnt_w(PTR);

  // One independent channel per lane; the top only slices the flat buses
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    neigh_fifo_ch #(
      .LEN       (LEN),
      .DEPTH     (DEPTH),
      .PTR       (PTR),
      .AF_MARGIN (AF_MARGIN)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .wr_data     (data_in[slice_lo(c, LEN) +: LEN]),
      .wr_valid    (data_in_valid[c]),
      .rd_rqst     (rd_rqst[c]),
      .full        (full[c]),
      .almost_full (almost_full[c]),
      .count       (count[slice_lo(c, CW) +: CW]),
      .rd_data     (data_out[slice_lo(c, LEN) +: LEN]),
      .rd_valid    (data_out_valid[c])
`ifdef NEIGH_FIFO_OVF_CNT_EN
      ,
      .ovf_cnt     (ovf_cnt[slice_lo(c, OVF_W) +: OVF_W])
`endif
    );
  end

endmodule

// File: tb/tb_neigh_fifo_mc.sv
// Directed table-driven bench for neigh_fifo_mc (LEN=16, DEPTH=4, NUM_CH=2, AF_MARGIN=1).
module tb_neigh_fifo_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] data_in = '0;
  logic [1:0]  data_in_valid = '0;
  logic [1:0]  rd_rqst = '0;
  logic [1:0]  full;
  logic [1:0]  almost_full;
  logic [5:0]  count;
  logic [31:0] data_out;
  logic [1:0]  data_out_valid;
`ifdef NEIGH_FIFO_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  int total  = 0;
  int passed = 0;

  neigh_fifo_mc #(
    .LEN(16), .DEPTH(4), .PTR(2), .NUM_CH(2), .AF_MARGIN(1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .rd_rqst        (rd_rqst),
    .full           (full),
    .almost_full    (almost_full),
    .count          (count),
    .data_out       (data_out),
    .data_out_valid (data_out_valid)
`ifdef NEIGH_FIFO_OVF_CNT_EN
    ,
    .ovf_cnt        (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [15:0] d0, d1;
    logic [1:0]  v, rr;
    logic [2:0]  c0, c1;
    logic [1:0]  f, af, dv;
    logic [15:0] o0, o1;
    logic [7:0]  ov1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic [15:0] d0, input logic [15:0] d1,
                              input logic [1:0] v, input logic [1:0] rr,
                              input logic [2:0] c0, input logic [2:0] c1,
                              input logic [1:0] f, input logic [1:0] af, input logic [1:0] dv,
                              input logic [15:0] o0, input logic [15:0] o1, input logic [7:0] ov1);
    vec_t r;
    r.st = st; r.d0 = d0; r.d1 = d1; r.v = v; r.rr = rr;
    r.c0 = c0; r.c1 = c1; r.f = f; r.af = af; r.dv = dv;
    r.o0 = o0; r.o1 = o1; r.ov1 = ov1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic st, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [1:0] v, input logic [1:0] rr);
    stall = st;
    data_in = {d1, d0};
    data_in_valid = v;
    rd_rqst = rr;
  endtask

  task automatic check_all(input string tag, input logic [2:0] c0, input logic [2:0] c1,
                           input logic [1:0] f, input logic [1:0] af, input logic [1:0] dv,
                           input logic [15:0] o0, input logic [15:0] o1);
    check({tag, ".count0"}, 32'(count[2:0]), 32'(c0));
    check({tag, ".count1"}, 32'(count[5:3]), 32'(c1));
    check({tag, ".full"}, 32'(full), 32'(f));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    check({tag, ".valid"}, 32'(data_out_valid), 32'(dv));
    check({tag, ".data0"}, 32'(data_out[15:0]), 32'(o0));
    check({tag, ".data1"}, 32'(data_out[31:16]), 32'(o1));
  endtask

  initial begin
    // st d0 d1 v rr | c0 c1 f af dv o0 o1 ovf1
    // Two writes then two-cycle read on ch0
    tbl.push_back(mk(0,16'hA1,0,2'b01,2'b00, 1,0,2'b00,2'b00,2'b00,16'h0,16'h0,0));
    tbl.push_back(mk(0,16'hA2,0,2'b01,2'b01, 2,0,2'b00,2'b00,2'b00,16'h0,16'h0,0));
    tbl.push_back(mk(0,0,0,2'b00,2'b01,      1,0,2'b00,2'b00,2'b01,16'hA1,16'h0,0));
    tbl.push_back(mk(0,0,0,2'b00,2'b00,      0,0,2'b00,2'b00,2'b01,16'hA2,16'h0,0));
    tbl.push_back(mk(0,0,0,2'b00,2'b00,      0,0,2'b00,2'b00,2'b00,16'hA2,16'h0,0));
    // Five writes to ch1, fifth dropped
    tbl.push_back(mk(0,0,16'h11,2'b10,2'b00, 0,1,2'b00,2'b00,2'b00,16'hA2,16'h0,0));
    tbl.push_back(mk(0,0,16'h12,2'b10,2'b00, 0,2,2'b00,2'b00,2'b00,16'hA2,16'h0,0));
    tbl.push_back(mk(0,0,16'h13,2'b10,2'b00, 0,3,2'b00,2'b10,2'b00,16'hA2,16'h0,0));
    tbl.push_back(mk(0,0,16'h14,2'b10,2'b00, 0,4,2'b10,2'b10,2'b00,16'hA2,16'h0,0));
    tbl.push_back(mk(0,0,16'h15,2'b10,2'b00, 0,4,2'b10,2'b10,2'b00,16'hA2,16'h0,1));
    // Fill ch0, then write-while-full with a same-cycle read, then drain in order
    tbl.push_back(mk(0,16'hB1,0,2'b01,2'b00, 1,4,2'b10,2'b10,2'b00,16'hA2,16'h0,1));
    tbl.push_back(mk(0,16'hB2,0,2'b01,2'b00, 2,4,2'b10,2'b10,2'b00,16'hA2,16'h0,1));
    tbl.push_back(mk(0,16'hB3,0,2'b01,2'b00, 3,4,2'b10,2'b11,2'b00,16'hA2,16'h0,1));
    tbl.push_back(mk(0,16'hB4,0,2'b01,2'b01, 4,4,2'b11,2'b11,2'b00,16'hA2,16'h0,1));
    tbl.push_back(mk(0,16'hB5,0,2'b01,2'b01, 4,4,2'b11,2'b11,2'b01,16'hB1,16'h0,1));
    tbl.push_back(mk(0,0,0,2'b00,2'b01,      3,4,2'b10,2'b11,2'b01,16'hB2,16'h0,1));
    tbl.push_back(mk(0,0,0,2'b00,2'b01,      2,4,2'b10,2'b10,2'b01,16'hB3,16'h0,1));
    tbl.push_back(mk(0,0,0,2'b00,2'b01,      1,4,2'b10,2'b10,2'b01,16'hB4,16'h0,1));
    tbl.push_back(mk(0,0,0,2'b00,2'b00,      0,4,2'b10,2'b10,2'b01,16'hB5,16'h0,1));
    tbl.push_back(mk(0,0,0,2'b00,2'b00,      0,4,2'b10,2'b10,2'b00,16'hB5,16'h0,1));
    // ch1: one read, then stall held three cycles with rd_rqst high
    tbl.push_back(mk(0,0,0,2'b00,2'b10,      0,4,2'b10,2'b10,2'b00,16'hB5,16'h0,1));
    tbl.push_back(mk(0,0,0,2'b00,2'b00,      0,3,2'b00,2'b10,2'b10,16'hB5,16'h11,1));
    tbl.push_back(mk(1,0,0,2'b00,2'b10,      0,3,2'b00,2'b10,2'b10,16'hB5,16'h11,1));
    tbl.push_back(mk(1,0,0,2'b00,2'b10,      0,3,2'b00,2'b10,2'b10,16'hB5,16'h11,1));
    tbl.push_back(mk(1,0,0,2'b00,2'b10,      0,3,2'b00,2'b10,2'b10,16'hB5,16'h11,1));
    tbl.push_back(mk(0,0,0,2'b00,2'b00,      0,3,2'b00,2'b10,2'b00,16'hB5,16'h11,1));
    // Pending request entering a stall is served exactly once
    tbl.push_back(mk(0,0,0,2'b00,2'b10,      0,3,2'b00,2'b10,2'b00,16'hB5,16'h11,1));
    tbl.push_back(mk(1,0,0,2'b00,2'b10,      0,2,2'b00,2'b00,2'b10,16'hB5,16'h12,1));
    tbl.push_back(mk(1,0,0,2'b00,2'b10,      0,2,2'b00,2'b00,2'b10,16'hB5,16'h12,1));
    tbl.push_back(mk(0,0,0,2'b00,2'b00,      0,2,2'b00,2'b00,2'b00,16'hB5,16'h12,1));
    // Request on empty ch0, then write: read issues the following cycle
    tbl.push_back(mk(0,0,0,2'b00,2'b01,      0,2,2'b00,2'b00,2'b00,16'hB5,16'h12,1));
    tbl.push_back(mk(0,16'hC3,0,2'b01,2'b01, 1,2,2'b00,2'b00,2'b00,16'hB5,16'h12,1));
    tbl.push_back(mk(0,0,0,2'b00,2'b01,      0,2,2'b00,2'b00,2'b01,16'hC3,16'h12,1));
    tbl.push_back(mk(0,0,0,2'b00,2'b00,      0,2,2'b00,2'b00,2'b00,16'hC3,16'h12,1));
    // Request on empty that drops before data arrives must not read
    tbl.push_back(mk(0,0,0,2'b00,2'b01,      0,2,2'b00,2'b00,2'b00,16'hC3,16'h12,1));
    tbl.push_back(mk(0,0,0,2'b00,2'b00,      0,2,2'b00,2'b00,2'b00,16'hC3,16'h12,1));
    tbl.push_back(mk(0,16'hC4,0,2'b01,2'b00, 1,2,2'b00,2'b00,2'b00,16'hC3,16'h12,1));
    tbl.push_back(mk(0,0,0,2'b00,2'b00,      1,2,2'b00,2'b00,2'b00,16'hC3,16'h12,1));
    tbl.push_back(mk(0,16'hC5,0,2'b01,2'b00, 2,2,2'b00,2'b00,2'b00,16'hC3,16'h12,1));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].d0, tbl[i].d1, tbl[i].v, tbl[i].rr);
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), tbl[i].c0, tbl[i].c1, tbl[i].f, tbl[i].af,
                tbl[i].dv, tbl[i].o0, tbl[i].o1);
`ifdef NEIGH_FIFO_OVF_CNT_EN
      check($sformatf("v%0d.ovf0", i), 32'(ovf_cnt[7:0]), 32'd0);
      check($sformatf("v%0d.ovf1", i), 32'(ovf_cnt[15:8]), 32'(tbl[i].ov1));
`endif
      @(negedge clk);
    end

    // Asynchronous reset mid-traffic with ch0 holding two entries
    drive(0, 16'hE1, 16'hE2, 2'b11, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
`ifdef NEIGH_FIFO_OVF_CNT_EN
    check("async_rst.ovf1", 32'(ovf_cnt[15:8]), 32'd0);
`endif
    @(posedge clk);
    #1;
    check_all("rst_held", 0, 0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Round trip after reset
    drive(0, 16'hD1, 16'h0, 2'b01, 2'b01);
    @(posedge clk);
    #1;
    check_all("post_rst_wr", 1, 0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    @(negedge clk);
    drive(0, 16'h0, 16'h0, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    check_all("post_rst_rd", 0, 0, 2'b00, 2'b00, 2'b01, 16'hD1, 16'h0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
